id_ex_stage: RTL and testbench

- Decode stage and ID/EX pipeline register for the MIPS-style core.
- Drives the register file read addresses from the incoming instruction and captures the operands it returns, with a same-cycle writeback bypass.
- Decodes the instruction and detects load-use hazards.
- Presents a registered, valid-qualified bundle to the execute stage.

---
 rtl/id_ex_stage.sv | 190 +++++++++++++++++++
 tb/tb_id_ex_stage.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// Decode stage and ID/EX pipeline register: operand fetch with writeback bypass,
// load-use hazard detection. Optional stall counter under `ID_STALL_STATS_EN.
module id_ex_stage #(
  parameter logic [4:0] LINK_REG       = 5'd31,
  parameter bit         ZERO_EXT_LOGIC = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] instr,
  output logic        id_ready,
  output logic [4:0]  reg1ad,
  output logic [4:0]  reg2ad,
  input  logic [31:0] reg1data,
  input  logic [31:0] reg2data,
  input  logic        wb_regwrite,
  input  logic [4:0]  wb_writead,
  input  logic [31:0] wb_data,
  input  logic        ex_stall,
  input  logic        flush,
  output logic        load_use_stall,
  output logic        ex_valid,
  output logic [5:0]  ex_opcode,
  output logic [5:0]  ex_funct,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [31:0] ex_rs_val,
  output logic [31:0] ex_rt_val,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rd,
  output logic        ex_regwrite,
  output logic        ex_memread,
  output logic        ex_memwrite
`ifdef ID_STALL_STATS_EN
  ,
  output logic [31:0] stall_count
`endif
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  logic [5:0]  w_opcode;
  logic [5:0]  w_funct;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd_field;
  logic [31:0] w_rs_val;
  logic [31:0] w_rt_val;
  logic        w_rs_used;
  logic        w_rt_used;
  logic [4:0]  w_dest;
  logic        w_dest_wr;
  logic        w_regwrite;
  logic        w_zext;
  logic [31:0] w_imm;
  logic        w_load_use;

  logic        r_valid;
  logic [5:0]  r_opcode;
  logic [5:0]  r_funct;
  logic [4:0]  r_rs;
  logic [4:0]  r_rt;
  logic [31:0] r_rs_val;
  logic [31:0] r_rt_val;
  logic [31:0] r_imm;
  logic [4:0]  r_rd;
  logic        r_regwrite;
  logic        r_memread;
  logic        r_memwrite;

  assign w_opcode   = instr[31:26];
  assign w_funct    = instr[5:0];
  assign w_rs       = instr[25:21];
  assign w_rt       = instr[20:16];
  assign w_rd_field = instr[15:11];

  assign reg1ad = w_rs;
  assign reg2ad = w_rt;

  // The register file writes on the edge, so a same-cycle writeback must be forwarded.
  assign w_rs_val = (wb_regwrite && (wb_writead != 5'd0) && (wb_writead == w_rs)) ? wb_data : reg1data;
  assign w_rt_val = (wb_regwrite && (wb_writead != 5'd0) && (wb_writead == w_rt)) ? wb_data : reg2data;

  assign w_rs_used = !((w_opcode == OP_J) || (w_opcode == OP_JAL) || (w_opcode == OP_LUI));
  assign w_rt_used = (w_opcode == OP_RTYPE) || (w_opcode == OP_BEQ) ||
                     (w_opcode == OP_BNE)   || (w_opcode == OP_SW);

  always_comb begin
    w_dest    = 5'd0;
    w_dest_wr = 1'b0;
    if (w_opcode == OP_RTYPE) begin
      w_dest    = w_rd_field;
      w_dest_wr = (w_funct != FN_JR);
    end else if ((w_opcode[5:3] == 3'b001) || (w_opcode == OP_LW)) begin
      w_dest    = w_rt;
      w_dest_wr = 1'b1;
    end else if (w_opcode == OP_JAL) begin
      w_dest    = LINK_REG;
      w_dest_wr = 1'b1;
    end
  end

  assign w_regwrite = w_dest_wr && (w_dest != 5'd0);

  assign w_zext = ZERO_EXT_LOGIC &&
                  ((w_opcode == OP_ANDI) || (w_opcode == OP_ORI) || (w_opcode == OP_XORI));
  assign w_imm  = w_zext ? {16'h0000, instr[15:0]} : {{16{instr[15]}}, instr[15:0]};

  assign w_load_use = in_valid && r_valid && r_memread && (r_rd != 5'd0) &&
                      ((w_rs_used && (r_rd == w_rs)) || (w_rt_used && (r_rd == w_rt)));

  assign load_use_stall = w_load_use;
  assign id_ready       = flush || (!ex_stall && !w_load_use);

  // Priority: flush, then EX stall (hold), then load-use bubble, then normal load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_opcode   <= 6'd0;
      r_funct    <= 6'd0;
      r_rs       <= 5'd0;
      r_rt       <= 5'd0;
      r_rs_val   <= 32'd0;
      r_rt_val   <= 32'd0;
      r_imm      <= 32'd0;
      r_rd       <= 5'd0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (ex_stall) begin
      r_valid <= r_valid;
    end else if (w_load_use) begin
      r_valid <= 1'b0;
    end else begin
      r_valid    <= in_valid;
      r_opcode   <= w_opcode;
      r_funct    <= w_funct;
      r_rs       <= w_rs;
      r_rt       <= w_rt;
      r_rs_val   <= w_rs_val;
      r_rt_val   <= w_rt_val;
      r_imm      <= w_imm;
      r_rd       <= w_dest;
      r_regwrite <= w_regwrite;
      r_memread  <= (w_opcode == OP_LW);
      r_memwrite <= (w_opcode == OP_SW);
    end
  end

  assign ex_valid    = r_valid;
  assign ex_opcode   = r_opcode;
  assign ex_funct    = r_funct;
  assign ex_rs       = r_rs;
  assign ex_rt       = r_rt;
  assign ex_rs_val   = r_rs_val;
  assign ex_rt_val   = r_rt_val;
  assign ex_imm      = r_imm;
  assign ex_rd       = r_rd;
  assign ex_regwrite = r_regwrite;
  assign ex_memread  = r_memread;
  assign ex_memwrite = r_memwrite;

`ifdef ID_STALL_STATS_EN
  logic [31:0] r_stall_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_count <= 32'd0;
    end else if (w_load_use && !flush && !ex_stall) begin
      r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed cases with literal expectations,
// then randomized traffic against a behavioural model of the decode/EX register.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] instr;
  logic        id_ready;
  logic [4:0]  reg1ad;
  logic [4:0]  reg2ad;
  logic [31:0] reg1data;
  logic [31:0] reg2data;
  logic        wb_regwrite;
  logic [4:0]  wb_writead;
  logic [31:0] wb_data;
  logic        ex_stall;
  logic        flush;
  logic        load_use_stall;
  logic        ex_valid;
  logic [5:0]  ex_opcode;
  logic [5:0]  ex_funct;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [31:0] ex_rs_val;
  logic [31:0] ex_rt_val;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rd;
  logic        ex_regwrite;
  logic        ex_memread;
  logic        ex_memwrite;
`ifdef ID_STALL_STATS_EN
  logic [31:0] stall_count;
`endif

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .instr(instr), .id_ready(id_ready),
    .reg1ad(reg1ad), .reg2ad(reg2ad), .reg1data(reg1data), .reg2data(reg2data),
    .wb_regwrite(wb_regwrite), .wb_writead(wb_writead), .wb_data(wb_data),
    .ex_stall(ex_stall), .flush(flush), .load_use_stall(load_use_stall),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_funct(ex_funct),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val),
    .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite)
`ifdef ID_STALL_STATS_EN
    , .stall_count(stall_count)
`endif
  );

  // Bench-owned register file; the DUT reads it through its address fields.
  logic [31:0] rf [32];
  assign reg1data = rf[instr[25:21]];
  assign reg2data = rf[instr[20:16]];

  typedef struct packed {
    logic        valid;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] rsv;
    logic [31:0] rtv;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
  } ex_t;

  int          checks   = 0;
  int          failures = 0;
  ex_t         m;
  logic [31:0] m_cnt;
  logic        hold_id;
  logic        e_lus;
  logic        e_ready;
  logic [5:0]  op_tab [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] byp(input logic [4:0] a);
    if (wb_regwrite && wb_writead != 5'd0 && wb_writead == a) return wb_data;
    return rf[a];
  endfunction

  function automatic ex_t decode(input logic [31:0] ins);
    ex_t d;
    logic [5:0] op;
    op    = ins[31:26];
    d     = '0;
    d.valid = 1'b1;
    d.op  = op;
    d.fn  = ins[5:0];
    d.rs  = ins[25:21];
    d.rt  = ins[20:16];
    d.rsv = byp(ins[25:21]);
    d.rtv = byp(ins[20:16]);
    d.mr  = (op == 6'h23);
    d.mw  = (op == 6'h2B);
    case (op)
      6'h00: begin d.rd = ins[15:11]; d.rw = (ins[5:0] != 6'h08); end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23:
             begin d.rd = ins[20:16]; d.rw = 1'b1; end
      6'h03: begin d.rd = 5'd31; d.rw = 1'b1; end
      default: d.rw = 1'b0;
    endcase
    if (d.rd == 5'd0) d.rw = 1'b0;
    if (op inside {6'h0C, 6'h0D, 6'h0E}) d.imm = {16'h0000, ins[15:0]};
    else                                 d.imm = {{16{ins[15]}}, ins[15:0]};
    return d;
  endfunction

  function automatic logic model_lus();
    logic [5:0] op;
    logic rs_used, rt_used;
    op      = instr[31:26];
    rs_used = !(op inside {6'h02, 6'h03, 6'h0F});
    rt_used = op inside {6'h00, 6'h04, 6'h05, 6'h2B};
    return in_valid && m.valid && m.mr && (m.rd != 5'd0) &&
           ((rs_used && m.rd == instr[25:21]) || (rt_used && m.rd == instr[20:16]));
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    r[31:26] = op_tab[$urandom_range(0, 15)];
    r[25:21] = 5'($urandom_range(0, 3));
    r[20:16] = 5'($urandom_range(0, 3));
    if (r[31:26] == 6'h00) begin
      r[15:11] = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) r[5:0] = 6'h08;
    end
    return r;
  endfunction

  task automatic check_ex(input ex_t e);
    chk("ex_valid", 32'(ex_valid), 32'(e.valid));
    if (e.valid) begin
      chk("ex_opcode",   32'(ex_opcode),   32'(e.op));
      chk("ex_funct",    32'(ex_funct),    32'(e.fn));
      chk("ex_rs",       32'(ex_rs),       32'(e.rs));
      chk("ex_rt",       32'(ex_rt),       32'(e.rt));
      chk("ex_rs_val",   ex_rs_val,        e.rsv);
      chk("ex_rt_val",   ex_rt_val,        e.rtv);
      chk("ex_imm",      ex_imm,           e.imm);
      chk("ex_regwrite", 32'(ex_regwrite), 32'(e.rw));
      chk("ex_memread",  32'(ex_memread),  32'(e.mr));
      chk("ex_memwrite", 32'(ex_memwrite), 32'(e.mw));
      if (e.rw || e.mr) chk("ex_rd", 32'(ex_rd), 32'(e.rd));
    end
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
  endtask

  initial begin
    op_tab = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
               6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h06};
    for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'd0 : 32'h1000_0000 + 32'(i) * 32'h0101_0101;
    rst_n = 1'b0; in_valid = 1'b0; instr = '0; wb_regwrite = 1'b0; wb_writead = '0;
    wb_data = '0; ex_stall = 1'b0; flush = 1'b0;
    #3;
    chk("rst_ex_valid",  32'(ex_valid), 32'd0);
    chk("rst_ex_rd",     32'(ex_rd), 32'd0);
    chk("rst_ex_imm",    ex_imm, 32'd0);
    chk("rst_ex_rs_val", ex_rs_val, 32'd0);
    chk("rst_ex_regwr",  32'(ex_regwrite), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // addi $t0,$zero,5 followed by an unrelated instruction
    instr = 32'h2008_0005; in_valid = 1'b1;
    tick();
    instr = 32'h0000_0000;
    chk("addi_valid", 32'(ex_valid), 32'd1);
    chk("addi_rd",    32'(ex_rd), 32'd8);
    chk("addi_imm",   ex_imm, 32'd5);
    chk("addi_regwr", 32'(ex_regwrite), 32'd1);
    tick();

    // writeback bypass on operand 1, then no bypass to $zero
    rf[9] = 32'd0;
    instr = 32'h2128_0000; wb_regwrite = 1'b1; wb_writead = 5'd9; wb_data = 32'hDEAD_BEEF;
    #1 chk("byp_reg1ad", 32'(reg1ad), 32'd9);
    tick();
    chk("byp_rs_val", ex_rs_val, 32'hDEAD_BEEF);
    wb_writead = 5'd0;
    tick();
    chk("nobyp_rs_val", ex_rs_val, 32'd0);
    wb_regwrite = 1'b0;

    // lw $t1,0($t2) then add $t3,$t1,$t1
    do_reset();
    instr = 32'h8D49_0000; in_valid = 1'b1;
    tick();
    chk("lw_memread", 32'(ex_memread), 32'd1);
    chk("lw_rd",      32'(ex_rd), 32'd9);
    instr = 32'h0129_5820;
    #1;
    chk("lu_stall",   32'(load_use_stall), 32'd1);
    chk("lu_idready", 32'(id_ready), 32'd0);
    tick();
    chk("lu_bubble",  32'(ex_valid), 32'd0);
    chk("lu_clear",   32'(load_use_stall), 32'd0);
    chk("lu_ready2",  32'(id_ready), 32'd1);
`ifdef ID_STALL_STATS_EN
    chk("lu_stall_count", stall_count, 32'd1);
`endif
    tick();
    chk("add_valid", 32'(ex_valid), 32'd1);
    chk("add_rd",    32'(ex_rd), 32'd11);
    chk("add_funct", 32'(ex_funct), 32'h20);

    // EX stall for three cycles holds the add bundle
    instr = 32'h2008_0005; ex_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1 chk("stall_idready", 32'(id_ready), 32'd0);
      tick();
      chk("stall_valid", 32'(ex_valid), 32'd1);
      chk("stall_rd",    32'(ex_rd), 32'd11);
      chk("stall_funct", 32'(ex_funct), 32'h20);
    end
    ex_stall = 1'b0;
    tick();
    chk("release_rd",  32'(ex_rd), 32'd8);
    chk("release_imm", ex_imm, 32'd5);
    chk("release_op",  32'(ex_opcode), 32'h08);

    // flush with valid ID and EX
    flush = 1'b1;
    #1 chk("flush_idready", 32'(id_ready), 32'd1);
    tick();
    chk("flush_valid", 32'(ex_valid), 32'd0);
    flush = 1'b0;

    // immediate extension
    instr = 32'h3008_8000;
    tick();
    chk("andi_imm", ex_imm, 32'h0000_8000);
    instr = 32'h2008_8000;
    tick();
    chk("addi_imm_neg", ex_imm, 32'hFFFF_8000);

    // async reset during a load-use stall
    instr = 32'h8D49_0000;
    tick();
    instr = 32'h0129_5820;
    #1 chk("ar_lus_pre", 32'(load_use_stall), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid",   32'(ex_valid), 32'd0);
    chk("ar_lus",     32'(load_use_stall), 32'd0);
    chk("ar_memread", 32'(ex_memread), 32'd0);
    chk("ar_rd",      32'(ex_rd), 32'd0);
    chk("ar_opcode",  32'(ex_opcode), 32'd0);
    chk("ar_rs_val",  ex_rs_val, 32'd0);
    chk("ar_imm",     ex_imm, 32'd0);
`ifdef ID_STALL_STATS_EN
    chk("ar_stall_count", stall_count, 32'd0);
`endif
    in_valid = 1'b0; instr = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // randomized traffic against the model
    m = '0; m_cnt = 32'd0; hold_id = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!hold_id) begin
        instr    = rand_instr();
        in_valid = ($urandom_range(0, 9) != 0);
      end
      ex_stall    = ($urandom_range(0, 6) == 0);
      flush       = ($urandom_range(0, 11) == 0);
      wb_regwrite = 1'($urandom_range(0, 1));
      wb_writead  = 5'($urandom_range(0, 3));
      wb_data     = $urandom;
      #1;
      e_lus   = model_lus();
      e_ready = flush || (!ex_stall && !e_lus);
      chk("r_lus",     32'(load_use_stall), 32'(e_lus));
      chk("r_idready", 32'(id_ready), 32'(e_ready));
      chk("r_reg1ad",  32'(reg1ad), 32'(instr[25:21]));
      chk("r_reg2ad",  32'(reg2ad), 32'(instr[20:16]));
`ifdef ID_STALL_STATS_EN
      chk("r_stall_count", stall_count, m_cnt);
`endif
      if (e_lus && !flush && !ex_stall) m_cnt = m_cnt + 32'd1;
      if (flush)          m.valid = 1'b0;
      else if (ex_stall)  m = m;
      else if (e_lus)     m.valid = 1'b0;
      else begin
        m       = decode(instr);
        m.valid = in_valid;
      end
      hold_id = !e_ready;
      tick();
      if (wb_regwrite && wb_writead != 5'd0) rf[wb_writead] = wb_data;
      check_ex(m);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
